// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_if
// Description : Byte-stream and instruction-memory write bundle for the
//               program loader.
//               Stream : in_data, in_valid (source -> loader), in_ready (back)
//               Memory : mem_write, mem_addr, mem_wdata (loader -> memory)
//               master = loader side, slave = source/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_write, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Fills instruction memory from a big-endian byte stream
//               (N_hi, N_lo, N*4 word bytes, XOR checksum) and holds the CPU
//               in reset until the image is loaded and verified.
// Ports       : clock        - system clock, rising edge
//               reset        - asynchronous active-low reset
//               start        - load request pulse (IDLE/DONE/ERROR only)
//               bus          - stream sink + memory write port (master)
//               cpu_reset_n  - active-low CPU reset, high only in DONE
//               done/error   - load status
//               words_loaded - words written in the current load
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              start,
  program_loader_if.master       bus,
  output logic                   cpu_reset_n,
  output logic                   done,
  output logic                   error,
  output logic [ADDR_WIDTH:0]    words_loaded
);

  localparam int         c_BYTES     = DATA_WIDTH / 8;
  // Largest legal word count; 17 bits so a 16-bit header can exceed it.
  localparam logic [16:0] c_CAPACITY = 17'd1 << ADDR_WIDTH;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_HDR_HI = 3'd1;
  localparam logic [2:0] c_HDR_LO = 3'd2;
  localparam logic [2:0] c_DATA   = 3'd3;
  localparam logic [2:0] c_WRITE  = 3'd4;
  localparam logic [2:0] c_CHECK  = 3'd5;
  localparam logic [2:0] c_DONE   = 3'd6;
  localparam logic [2:0] c_ERROR  = 3'd7;

  logic [2:0]            r_state;
  logic [2:0]            w_next_state;
  logic [15:0]           r_n;
  logic [7:0]            r_csum;
  logic [DATA_WIDTH-9:0] r_word;       // first three bytes of the word in flight
  logic [1:0]            r_byte_cnt;
  logic [ADDR_WIDTH:0]   r_words;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  logic                  w_accept;
  logic                  w_restart;
  logic                  w_last_byte;
  logic [15:0]           w_n_full;
  logic                  w_oversize;
  logic [ADDR_WIDTH:0]   w_words_inc;

  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_restart   = start && ((r_state == c_IDLE) || (r_state == c_DONE) ||
                                 (r_state == c_ERROR));
  assign w_last_byte = (r_byte_cnt == 2'(c_BYTES - 1));
  // Full word count as seen while the low header byte is on the bus.
  assign w_n_full    = {r_n[15:8], bus.in_data};
  assign w_oversize  = {1'b0, w_n_full} > c_CAPACITY;
  assign w_words_inc = r_words + 1'b1;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE, c_DONE, c_ERROR: begin
        if (start) w_next_state = c_HDR_HI;
      end
      c_HDR_HI: begin
        if (w_accept) w_next_state = c_HDR_LO;
      end
      c_HDR_LO: begin
        if (w_accept) begin
          if (w_n_full == 16'd0) w_next_state = c_CHECK;
          else if (w_oversize)   w_next_state = c_ERROR;
          else                   w_next_state = c_DATA;
        end
      end
      c_DATA: begin
        if (w_accept && w_last_byte) w_next_state = c_WRITE;
      end
      c_WRITE: begin
        w_next_state = (17'(w_words_inc) == {1'b0, r_n}) ? c_CHECK : c_DATA;
      end
      c_CHECK: begin
        if (w_accept) w_next_state = (bus.in_data == r_csum) ? c_DONE : c_ERROR;
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.mem_write = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    cpu_reset_n   = 1'b0;
    case (r_state)
      c_HDR_HI, c_HDR_LO, c_DATA, c_CHECK: bus.in_ready = 1'b1;
      c_WRITE: bus.mem_write = 1'b1;
      c_DONE: begin
        done        = 1'b1;
        cpu_reset_n = 1'b1;
      end
      c_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: header, checksum, word assembly, write address/data
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_n         <= '0;
      r_csum      <= '0;
      r_word      <= '0;
      r_byte_cnt  <= '0;
      r_words     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_restart) begin
        r_csum     <= '0;
        r_words    <= '0;
        r_byte_cnt <= '0;
      end
      // The checksum byte itself is never folded into the running XOR.
      if (w_accept && (r_state != c_CHECK)) begin
        r_csum <= r_csum ^ bus.in_data;
      end
      if (w_accept) begin
        case (r_state)
          c_HDR_HI: r_n[15:8] <= bus.in_data;
          c_HDR_LO: r_n[7:0]  <= bus.in_data;
          c_DATA: begin
            r_word     <= {r_word[DATA_WIDTH-17:0], bus.in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Address/data are captured here so they are valid throughout
            // WRITE and hold afterwards.
            if (w_last_byte) begin
              r_mem_addr  <= r_words[ADDR_WIDTH-1:0];
              r_mem_wdata <= {r_word, bus.in_data};
            end
          end
          default: ;
        endcase
      end
      if (r_state == c_WRITE) begin
        r_words <= w_words_inc;
      end
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign words_loaded  = r_words;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Table of load
//               scenarios plus hand sequences for reset mid-load and start
//               during DATA; writes are checked against a stream-parsing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;
  localparam int AW  = 8;
  localparam int CAP = 1 << AW;

  localparam int K_PLAN  = 0;  // the two fixed words 20080005 / 01095020
  localparam int K_RAND  = 1;  // fresh random words
  localparam int K_REUSE = 2;  // the previous random words again
  localparam int K_BEEF  = 3;  // single DEADBEEF word

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          cpu_reset_n;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  program_loader_if #(.ADDR_WIDTH(AW)) bus();

  program_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (bus.master),
    .cpu_reset_n  (cpu_reset_n),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int         n;
    int         kind;
    logic [7:0] mask;
    bit         gaps;
    bit         csum;
    bit         exp_done;
    bit         exp_err;
    int         exp_words;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] tb_mem  [CAP];
  logic [31:0] exp_mem [CAP];
  logic [31:0] save_mem[CAP];
  logic [31:0] rnd_words[CAP];
  wr_t         exp_wr[$];
  wr_t         mon_w;
  logic [7:0]  tx_q[$];
  vec_t        vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the model's next write.
  always @(negedge clock) begin
    if (reset && bus.mem_write) begin
      check("in_ready_during_write", 64'(bus.in_ready), 64'd0);
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, none required",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_w = exp_wr.pop_front();
        check("write_addr", 64'(bus.mem_addr), 64'(mon_w.addr));
        check("write_data", 64'(bus.mem_wdata), 64'(mon_w.data));
      end
      tb_mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // Builds the byte stream for a load into tx_q.
  task automatic build(input int n, input int kind, input logic [7:0] mask, input bit with_csum);
    logic [7:0]  x;
    logic [31:0] w;
    tx_q.delete();
    tx_q.push_back(8'(n >> 8));
    tx_q.push_back(8'(n));
    if (n <= CAP) begin
      for (int i = 0; i < n; i++) begin
        case (kind)
          K_PLAN:  w = (i == 0) ? 32'h20080005 : 32'h01095020;
          K_BEEF:  w = 32'hDEADBEEF;
          K_REUSE: w = rnd_words[i];
          default: begin
            w = $urandom;
            rnd_words[i] = w;
          end
        endcase
        for (int b = 3; b >= 0; b--) tx_q.push_back(8'(w >> (8 * b)));
      end
    end
    if (with_csum) begin
      x = 8'h00;
      foreach (tx_q[i]) x = x ^ tx_q[i];
      tx_q.push_back(x ^ mask);
    end
  endtask

  // Reference model: parse the stream and list the memory writes it implies.
  task automatic model_load(input logic [7:0] s[$]);
    int  n;
    wr_t w;
    n = int'(s[0]) * 256 + int'(s[1]);
    if (n > CAP) return;
    for (int i = 0; i < n; i++) begin
      w.addr = i;
      w.data = {s[2 + 4 * i], s[3 + 4 * i], s[4 + 4 * i], s[5 + 4 * i]};
      exp_wr.push_back(w);
      exp_mem[i] = w.data;
    end
  endtask

  // Sends up to max_bytes of tx_q; the source holds a byte until accepted.
  task automatic drive(input int max_bytes, input bit gaps);
    int sent   = 0;
    int budget = 20000;
    while (tx_q.size() > 0 && sent < max_bytes && budget > 0) begin
      @(negedge clock);
      budget--;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = tx_q[0];
      end
      if (bus.in_valid && bus.in_ready) begin
        void'(tx_q.pop_front());
        sent++;
      end
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drive_timeout: %0d bytes left, 0 required", tx_q.size());
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_image();
    int bad = 0;
    for (int i = 0; i < CAP; i++) if (tb_mem[i] !== exp_mem[i]) bad++;
    check("mem_image_mismatches", 64'(bad), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_mem_write", 64'(bus.mem_write), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_words_loaded", 64'(words_loaded), 64'd0);
  endtask

  initial begin
    //           n    kind     mask  gaps csum done err words
    vecs[0] = '{2,   K_PLAN,  8'h00, 0, 1, 1, 0, 2};
    vecs[1] = '{2,   K_PLAN,  8'h01, 0, 1, 0, 1, 2};
    vecs[2] = '{257, K_PLAN,  8'h00, 0, 0, 0, 1, 0};
    vecs[3] = '{0,   K_PLAN,  8'h00, 0, 1, 1, 0, 0};
    vecs[4] = '{0,   K_PLAN,  8'h01, 0, 1, 0, 1, 0};
    vecs[5] = '{4,   K_RAND,  8'h00, 0, 1, 1, 0, 4};
    vecs[6] = '{4,   K_REUSE, 8'h00, 1, 1, 1, 0, 4};
    vecs[7] = '{256, K_RAND,  8'h00, 1, 1, 1, 0, 256};
    vecs[8] = '{3,   K_RAND,  8'h5A, 1, 1, 0, 1, 3};
    vecs[9] = '{1,   K_RAND,  8'h00, 1, 1, 1, 0, 1};

    for (int i = 0; i < CAP; i++) begin
      tb_mem[i]  = 32'h0;
      exp_mem[i] = 32'h0;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);

    foreach (vecs[v]) begin
      pulse_start();
      build(vecs[v].n, vecs[v].kind, vecs[v].mask, vecs[v].csum);
      model_load(tx_q);
      drive(1 << 20, vecs[v].gaps);
      // One negedge after the final accept: status must already be visible.
      check($sformatf("v%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
      check($sformatf("v%0d_error", v), 64'(error), 64'(vecs[v].exp_err));
      check($sformatf("v%0d_cpu_reset_n", v), 64'(cpu_reset_n), 64'(vecs[v].exp_done));
      check($sformatf("v%0d_words_loaded", v), 64'(words_loaded), 64'(vecs[v].exp_words));
      check($sformatf("v%0d_in_ready", v), 64'(bus.in_ready), 64'd0);
      check($sformatf("v%0d_missing_writes", v), 64'(exp_wr.size()), 64'd0);
      check_image();
    end

    // Reset in the middle of DATA after 6 bytes (one word already written).
    pulse_start();
    build(2, K_RAND, 8'h00, 1);
    save_mem = exp_mem;
    model_load(tx_q);
    drive(6, 0);
    @(negedge clock);
    check("mid_in_ready", 64'(bus.in_ready), 64'd1);
    check("mid_pending_writes", 64'(exp_wr.size()), 64'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    while (exp_wr.size() > 0) begin
      mon_w = exp_wr.pop_front();
      exp_mem[mon_w.addr] = save_mem[mon_w.addr];
    end
    tx_q.delete();
    repeat (2) @(negedge clock);
    check_reset_outputs();
    reset = 1'b1;

    // N=1 DEADBEEF load with a start pulse while in DATA.
    pulse_start();
    build(1, K_BEEF, 8'h00, 1);
    model_load(tx_q);
    drive(4, 0);
    pulse_start();
    check("start_in_data_ready", 64'(bus.in_ready), 64'd1);
    check("start_in_data_done", 64'(done), 64'd0);
    drive(1 << 20, 0);
    check("beef_done", 64'(done), 64'd1);
    check("beef_cpu_reset_n", 64'(cpu_reset_n), 64'd1);
    check("beef_words_loaded", 64'(words_loaded), 64'd1);
    check("beef_mem0", 64'(tb_mem[0]), 64'h0000_0000_DEAD_BEEF);
    check("beef_missing_writes", 64'(exp_wr.size()), 64'd0);
    check_image();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
Hardware loader that fills the CPU instruction memory from a byte stream and holds the CPU in reset until the image is complete and verified. It sits between an external byte source and the instruction memory write port, upstream of the CPU reset input. Its job is to write program words into instruction memory and then release the CPU.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction memory; capacity is 2^ADDR_WIDTH 32-bit words.
DATA_WIDTH, 32, instruction word width; fixed at 32, with 4 bytes per word.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts a byte this cycle; the transfer occurs on in_valid && in_ready.
mem_write  output  1  one-cycle instruction memory write strobe.
mem_addr  output  ADDR_WIDTH  word index for the write.
mem_wdata  output  32  word to write.
cpu_reset_n  output  1  active-low CPU reset; low while not DONE.
done  output  1  image loaded and checksum matched.
error  output  1  oversize count or checksum mismatch.
words_loaded  output  ADDR_WIDTH+1  count of words written in the current load.

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE.
  - in_ready=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - cpu_reset_n=0, done=0, error=0, words_loaded=0.
  - Internal byte counter, word count N and running checksum cleared.
- Stream format, big-endian:
  - N_hi, N_lo: 16-bit word count.
  - N×4 instruction bytes.
  - 1 checksum byte equal to the XOR of every preceding byte, header included.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE:
  - in_ready=0.
  - start → HDR_HI. On this transition: checksum=0, words_loaded=0, done=0, error=0, cpu_reset_n=0.
- HDR_HI: in_ready=1. On accept, latch N[15:8] → HDR_LO.
- HDR_LO: in_ready=1. On accept, latch N[7:0]. Then:
  - N=0 → CHECK.
  - N>2^ADDR_WIDTH → ERROR. The checksum byte is not consumed.
  - Otherwise → DATA.
- DATA:
  - in_ready=1.
  - Bytes shift into a word register MSB-first.
  - Accepting the 4th byte of a word → WRITE.
- WRITE (exactly 1 cycle):
  - in_ready=0, mem_write=1, mem_addr=words_loaded[ADDR_WIDTH-1:0], mem_wdata=assembled word.
  - words_loaded increments at the end of the cycle.
  - Next state: CHECK if the new words_loaded==N, else DATA.
  - Latency: 4th byte accepted at edge k, mem_write high in the cycle after edge k.
- CHECK: in_ready=1. On accept, compare the byte with the running XOR.
  - Equal → DONE.
  - Unequal → ERROR.
- DONE:
  - done=1, cpu_reset_n=1, in_ready=0.
  - Both outputs become high in the cycle after the checksum byte is accepted.
- ERROR: error=1, cpu_reset_n=0, in_ready=0.
- The checksum accumulates on every accepted byte except the checksum byte itself.
- mem_write is high only in WRITE. mem_addr and mem_wdata hold their last values otherwise.
- start in HDR_HI, HDR_LO, DATA, WRITE or CHECK is ignored.
- start in DONE or ERROR restarts the load:
  - Next cycle: state=HDR_HI, done=0, error=0, cpu_reset_n=0, words_loaded=0.
  - Memory contents are not cleared.
- in_valid while in_ready=0: the byte is not consumed, and the source holds it.
- reset asserted mid-load: immediate return to reset values. A partially written memory is left as is.
- words_loaded is ADDR_WIDTH+1 bits wide, so a full load reads 2^ADDR_WIDTH without wrapping. mem_addr never exceeds 2^ADDR_WIDTH-1.

Test Plan:
1. Reset, start, then stream 00 02 | 20 08 00 05 | 01 09 50 20 | checksum.
   - Expected: mem_write twice, at addresses 0 and 1, with data 32'h20080005 and 32'h01095020.
   - Then done=1, cpu_reset_n=1, words_loaded=2.
2. Same stream with the checksum byte XORed with 8'h01.
   - Expected: both words are still written, then error=1, done=0, cpu_reset_n=0.
3. Header 01 01 (N=257) with ADDR_WIDTH=8.
   - Expected: ERROR the cycle after the second byte, no mem_write, in_ready=0.
4. Header 00 00, then checksum byte 00.
   - Expected: DONE with no writes and words_loaded=0.
   - Repeat with checksum 01: ERROR.
5. Backpressure and gaps:
   - Hold in_valid high continuously and check in_ready=0 during each WRITE cycle. No byte may be lost or duplicated; verify memory against the expected image for N=4.
   - Insert random in_valid gaps; the result must be identical.
6. Assert reset mid-DATA after 6 bytes, then release, start, and load N=1 with word 32'hDEADBEEF.
   - Expected: all outputs at reset values during reset.
   - After the new load: address 0 = 32'hDEADBEEF, done=1.
   - A start pulse issued during DATA is ignored.
